// File: rtl/full_adder_half_adder.sv
// Full adder built from two half adders and an OR gate, with registered
// copies of the sum and carry and a saturating carry-event counter.
//
// Ports:
//   clk_i       : clock; all state changes on the rising edge
//   reset_n_i   : synchronous active-low reset of the registered outputs
//   a_i, b_i    : addend bits
//   cin_i       : carry in
//   sum_o       : combinational sum, a ^ b ^ cin
//   cout_o      : combinational carry out
//   sum_r_o     : sum_o delayed by one clock
//   cout_r_o    : cout_o delayed by one clock
//   carry_cnt_o : number of sampled edges with cout_o = 1, saturating

// Half adder: s = x ^ y, c = x & y.
//   i_x, i_y : operand bits
//   o_s      : sum bit
//   o_c      : carry bit
module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;

endmodule

module full_adder_half_adder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             cin_i,
  output logic             sum_o,
  output logic             cout_o,
  output logic             sum_r_o,
  output logic             cout_r_o,
  output logic [CNT_W-1:0] carry_cnt_o
);

  logic w_ha1_s;
  logic w_ha1_c;
  logic w_ha2_s;
  logic w_ha2_c;

  logic             r_sum;
  logic             r_cout;
  logic [CNT_W-1:0] r_carry_cnt;

  half_adder u_ha1 (
    .i_x (a_i),
    .i_y (b_i),
    .o_s (w_ha1_s),
    .o_c (w_ha1_c)
  );

  half_adder u_ha2 (
    .i_x (w_ha1_s),
    .i_y (cin_i),
    .o_s (w_ha2_s),
    .o_c (w_ha2_c)
  );

  // Combinational path is independent of clock and reset.
  assign sum_o  = w_ha2_s;
  assign cout_o = w_ha1_c | w_ha2_c;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_sum       <= 1'b0;
      r_cout      <= 1'b0;
      r_carry_cnt <= '0;
    end else begin
      r_sum  <= sum_o;
      r_cout <= cout_o;
      // Hold at all-ones rather than wrapping.
      if (cout_o && (r_carry_cnt != '1)) begin
        r_carry_cnt <= r_carry_cnt + 1'b1;
      end
    end
  end

  assign sum_r_o     = r_sum;
  assign cout_r_o    = r_cout;
  assign carry_cnt_o = r_carry_cnt;

endmodule

// File: tb/tb_full_adder_half_adder.sv
module tb_full_adder_half_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, cin;

  logic       sum, cout, sum_r, cout_r;
  logic [7:0] cnt;
  logic       sum2, cout2, sum_r2, cout_r2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the registered outputs should hold.
  logic m_sum_r, m_cout_r;
  int   m_cnt, m_cnt2;

  always #5 clk = ~clk;

  full_adder_half_adder #(.CNT_W(8)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sum_o       (sum),
    .cout_o      (cout),
    .sum_r_o     (sum_r),
    .cout_r_o    (cout_r),
    .carry_cnt_o (cnt)
  );

  full_adder_half_adder #(.CNT_W(2)) dut_small (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sum_o       (sum2),
    .cout_o      (cout2),
    .sum_r_o     (sum_r2),
    .cout_r_o    (cout_r2),
    .carry_cnt_o (cnt2)
  );

  // Advance one rising edge and update the reference from the arithmetic
  // value of the inputs sampled at that edge.
  task automatic step();
    int total;
    @(posedge clk);
    total = int'(a) + int'(b) + int'(cin);
    if (!rst_n) begin
      m_sum_r  = 1'b0;
      m_cout_r = 1'b0;
      m_cnt    = 0;
      m_cnt2   = 0;
    end else begin
      m_sum_r  = (total % 2) == 1;
      m_cout_r = total >= 2;
      if (total >= 2) begin
        m_cnt  = (m_cnt  + 1 > 255) ? 255 : m_cnt + 1;
        m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; cin = 1'b1;
    step();
    n_checks++;
    if ({sum_r, cout_r, cnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: got sum_r=%b cout_r=%b cnt=%0d, want 0 0 0", sum_r, cout_r, cnt);
    end
    n_checks++;
    if ({sum_r2, cout_r2, cnt2} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state_small: got sum_r=%b cout_r=%b cnt=%0d, want 0 0 0", sum_r2, cout_r2, cnt2);
    end
  endtask

  task automatic test_comb_sweep(input logic rst_val);
    logic [7:0] exp_sum_tbl;
    logic [7:0] exp_cout_tbl;
    int total;
    exp_sum_tbl  = 8'b1001_0110; // index 0 is LSB: 0,1,1,0,1,0,0,1
    exp_cout_tbl = 8'b1110_1000; // 0,0,0,1,0,1,1,1
    rst_n = rst_val;
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #1;
      total = int'(a) + int'(b) + int'(cin);
      n_checks++;
      if (sum !== exp_sum_tbl[i] || sum !== ((total % 2) == 1)) begin
        n_fail++;
        $display("FAIL comb_sum rst=%b abc=%03b: got %b, want %b", rst_val, 3'(i), sum, exp_sum_tbl[i]);
      end
      n_checks++;
      if (cout !== exp_cout_tbl[i] || cout !== (total >= 2)) begin
        n_fail++;
        $display("FAIL comb_cout rst=%b abc=%03b: got %b, want %b", rst_val, 3'(i), cout, exp_cout_tbl[i]);
      end
    end
  endtask

  task automatic test_load();
    rst_n = 1'b0;
    step();
    a = 1'b1; b = 1'b1; cin = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (sum_r !== 1'b0 || cout_r !== 1'b1 || cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL load_110: got sum_r=%b cout_r=%b cnt=%0d, want 0 1 1", sum_r, cout_r, cnt);
    end
  endtask

  task automatic test_carry3();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a = 1'b1; b = 1'b1; cin = 1'b1;
    repeat (3) step();
    n_checks++;
    if (sum_r !== 1'b1 || cout_r !== 1'b1 || cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL carry3_111: got sum_r=%b cout_r=%b cnt=%0d, want 1 1 3", sum_r, cout_r, cnt);
    end
  endtask

  task automatic test_reset_priority();
    a = 1'b1; b = 1'b0; cin = 1'b1;
    rst_n = 1'b0;
    step();
    n_checks++;
    if (sum_r !== 1'b0 || cout_r !== 1'b0 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_priority: got sum_r=%b cout_r=%b cnt=%0d, want 0 0 0", sum_r, cout_r, cnt);
    end
    // Combinational outputs stay live during reset.
    n_checks++;
    if (cout !== 1'b1 || sum !== 1'b0) begin
      n_fail++;
      $display("FAIL comb_during_reset: got sum=%b cout=%b, want 0 1", sum, cout);
    end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a = 1'b1; b = 1'b1; cin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (int'(cnt2) !== m_cnt2 || int'(cnt2) !== ((k > 3) ? 3 : k)) begin
        n_fail++;
        $display("FAIL saturation edge %0d: got cnt=%0d, want %0d", k, cnt2, m_cnt2);
      end
    end
    n_checks++;
    if (cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL wide_count_5: got cnt=%0d, want 5", cnt);
    end
  endtask

  // Random traffic with occasional resets and mid-cycle glitches on the
  // inputs; only the value present at the edge may be captured.
  task automatic test_random();
    int total;
    rst_n = 1'b0;
    step();
    for (int i = 0; i < 300; i++) begin
      {a, b, cin} = 3'($urandom_range(0, 7));
      #2;
      {a, b, cin} = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      total = int'(a) + int'(b) + int'(cin);
      n_checks++;
      if (sum !== ((total % 2) == 1) || cout !== (total >= 2)) begin
        n_fail++;
        $display("FAIL random_comb %0d: got sum=%b cout=%b, want %b %b", i, sum, cout, (total % 2) == 1, total >= 2);
      end
      step();
      n_checks++;
      if (sum_r !== m_sum_r || cout_r !== m_cout_r || int'(cnt) !== m_cnt || int'(cnt2) !== m_cnt2) begin
        n_fail++;
        $display("FAIL random_reg %0d: got %b %b %0d %0d, want %b %b %0d %0d", i,
                 sum_r, cout_r, cnt, cnt2, m_sum_r, m_cout_r, m_cnt, m_cnt2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] pat [4];
    pat[0] = 3'b011; pat[1] = 3'b100; pat[2] = 3'b111; pat[3] = 3'b000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b, cin} = pat[i];
      step();
      n_checks++;
      if (sum_r !== m_sum_r || cout_r !== m_cout_r || int'(cnt) !== m_cnt) begin
        n_fail++;
        $display("FAIL back_to_back %0d: got %b %b %0d, want %b %b %0d", i,
                 sum_r, cout_r, cnt, m_sum_r, m_cout_r, m_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0;
    m_sum_r = 1'b0; m_cout_r = 1'b0; m_cnt = 0; m_cnt2 = 0;
    test_reset();
    test_comb_sweep(1'b0);
    test_comb_sweep(1'b1);
    test_load();
    test_carry3();
    test_reset_priority();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_half_adder.md
FULL_ADDER_HALF_ADDER -- requirements
Module: full_adder_half_adder

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8, width of the carry-event counter.

Ports:
REQ-002 The block SHALL have clk_i, input, 1, the single clock; all sequential logic is on its rising edge.
REQ-003 The block SHALL have reset_n_i, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-004 The block SHALL have a_i, input, 1, addend A.
REQ-005 The block SHALL have b_i, input, 1, addend B.
REQ-006 The block SHALL have cin_i, input, 1, carry in.
REQ-007 The block SHALL have sum_o, output, 1, combinational sum bit.
REQ-008 The block SHALL have cout_o, output, 1, combinational carry out.
REQ-009 The block SHALL have sum_r_o, output, 1, sum_o registered one cycle.
REQ-010 The block SHALL have cout_r_o, output, 1, cout_o registered one cycle.
REQ-011 The block SHALL have carry_cnt_o, output, CNT_W, count of cycles sampled with cout_o=1.

Function
REQ-012 The block SHALL be built from two instances of a half-adder submodule (s = x^y, c = x&y) plus a 2-input OR.
- HA1 inputs are a_i and b_i.
- HA2 inputs are HA1 sum and cin_i.
REQ-013 sum_o SHALL equal a_i ^ b_i ^ cin_i.
REQ-014 cout_o SHALL equal (a_i & b_i) | ((a_i ^ b_i) & cin_i), i.e. the HA1 carry ORed with the HA2 carry.
REQ-015 sum_o and cout_o SHALL be purely combinational:
- zero clock latency;
- independent of clk_i and reset_n_i, including while reset is asserted;
- settled within 1 ns of any input change in simulation (no delays modeled).
REQ-016 sum_o/cout_o SHALL never be X or Z when a_i, b_i and cin_i are all known (0/1).
REQ-017 On each rising clk_i edge with reset_n_i=1, sum_r_o and cout_r_o SHALL load sum_o and cout_o, giving 1-cycle latency.
REQ-018 On each rising clk_i edge with reset_n_i=1 and cout_o=1, carry_cnt_o SHALL increment by 1.
REQ-019 carry_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Input changes between clock edges SHALL affect registered outputs only through the value sampled at the next rising edge.

Reset
REQ-021 On a rising clk_i edge with reset_n_i=0, sum_r_o, cout_r_o and carry_cnt_o SHALL all become 0.
REQ-022 Reset SHALL take priority over the load/increment in the same edge.
REQ-023 Before the first clock edge, registered outputs SHALL be undefined (no asynchronous effect).
REQ-024 Reset SHALL NOT affect sum_o/cout_o.
REQ-025 Deasserting reset mid-operation SHALL resume normal registering at the next edge.

Verification
REQ-026 With reset_n_i=0, apply all 8 {a,b,cin} combinations (000..111) and check each 1 ns later:
- sum_o = 0,1,1,0,1,0,0,1;
- cout_o = 0,0,0,1,0,1,1,1.
REQ-027 Repeat the 8-combination sweep after reset release: identical combinational results, PASS on every case.
REQ-028 Hold a=1,b=1,cin=0, release reset, clock one edge -> sum_r_o=0, cout_r_o=1, carry_cnt_o=1.
REQ-029 Hold a=1,b=1,cin=1 for 3 edges after reset -> carry_cnt_o=3, sum_r_o=1, cout_r_o=1.
REQ-030 Assert reset_n_i=0 for one edge with cout_o=1 -> sum_r_o, cout_r_o and carry_cnt_o all 0 after that edge.
REQ-031 With CNT_W=2, hold cout_o=1 for 5 edges -> carry_cnt_o stays at 3 (saturation).
